mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Pipeline memory-access stage: issues one load/store per EX op to a RAM port and produces the writeback.
// Latency: ALU results and address errors appear one cycle after EX; memory ops write back one cycle after ram_ack.
// Backpressure: stall_req holds EX while a request is being issued or is awaiting ram_ack.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush, ex_valid                EX op qualifiers (flush discards / suppresses writeback)
//   mem_read, mem_write, mem_size,
//   mem_sign, address, write_data  memory op description from EX
//   ex_result, wb_reg              non-memory result and destination register
//   ram_req/we/addr/sel/wdata      RAM request, held constant until ram_ack
//   ram_ack, ram_rdata             RAM completion and load word
//   stall_req                      hold EX/upstream this cycle
//   wb_valid, wb_reg_out, wb_data  writeback pulse
//   addr_error, bus_error          misalignment / ack-timeout pulses
module mem_access #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [31:0] ex_result,
   input  logic [4:0]  wb_reg,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_sel,
   output logic [31:0] ram_wdata,
   input  logic        ram_ack,
   input  logic [31:0] ram_rdata,
   output logic        stall_req,
   output logic        wb_valid,
   output logic [4:0]  wb_reg_out,
   output logic [31:0] wb_data,
   output logic        addr_error,
   output logic        bus_error
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] TMO = CW'(ACK_TIMEOUT);

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    op_size;
   logic          op_sign;
   logic [1:0]    op_off;
   logic [4:0]    op_reg;
   logic          op_flushed;

   logic          is_mem, any_mem, size_ok, misaligned;
   logic          issue, alu_wb, mis_err, ack_done, timeout;
   logic [3:0]    sel;
   logic [31:0]   wdata, lane, load_data;

   // Exactly one of read/write makes a legal memory op; both set is a no-op.
   assign any_mem    = mem_read | mem_write;
   assign is_mem     = mem_read ^ mem_write;
   assign size_ok    = (mem_size != 2'b11);
   assign misaligned = ((mem_size == 2'b01) && address[0]) ||
                       ((mem_size == 2'b10) && (address[1:0] != 2'b00));

   always_comb begin
      state_nxt = state;
      stall_req = 1'b0;
      issue     = 1'b0;
      alu_wb    = 1'b0;
      mis_err   = 1'b0;
      ack_done  = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (ex_valid && !flush) begin
               if (!any_mem) begin
                  alu_wb = 1'b1;
               end else if (is_mem && size_ok) begin
                  if (misaligned) begin
                     mis_err = 1'b1;
                  end else begin
                     issue     = 1'b1;
                     stall_req = 1'b1;
                     state_nxt = ACCESS;
                  end
               end
            end
         end
         ACCESS: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (ram_ack) begin
               ack_done  = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == TMO) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall_req = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         stall_req = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Little-endian lane enables and lane-replicated store data.
   always_comb begin
      sel   = 4'b1111;
      wdata = write_data;
      case (mem_size)
         2'b00: begin
            sel   = 4'b0001 << address[1:0];
            wdata = {4{write_data[7:0]}};
         end
         2'b01: begin
            sel   = address[1] ? 4'b1100 : 4'b0011;
            wdata = {2{write_data[15:0]}};
         end
         default: begin
            sel   = 4'b1111;
            wdata = write_data;
         end
      endcase
   end

   assign lane = ram_rdata >> {op_off, 3'b000};

   always_comb begin
      load_data = lane;
      case (op_size)
         2'b00:   load_data = {{24{op_sign & lane[7]}}, lane[7:0]};
         2'b01:   load_data = {{16{op_sign & lane[15]}}, lane[15:0]};
         default: load_data = lane;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt   <= '0;
         op_size    <= 2'b00;
         op_sign    <= 1'b0;
         op_off     <= 2'b00;
         op_reg     <= 5'd0;
         op_flushed <= 1'b0;
         ram_req    <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= 32'd0;
         ram_sel    <= 4'd0;
         ram_wdata  <= 32'd0;
         wb_valid   <= 1'b0;
         wb_reg_out <= 5'd0;
         wb_data    <= 32'd0;
         addr_error <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         wb_valid   <= 1'b0;
         addr_error <= 1'b0;
         bus_error  <= 1'b0;

         if (alu_wb) begin
            wb_valid   <= 1'b1;
            wb_data    <= ex_result;
            wb_reg_out <= wb_reg;
         end

         if (mis_err) begin
            addr_error <= 1'b1;
         end

         if (issue) begin
            ram_req    <= 1'b1;
            ram_we     <= mem_write;
            ram_addr   <= {address[31:2], 2'b00};
            ram_sel    <= sel;
            ram_wdata  <= wdata;
            op_size    <= mem_size;
            op_sign    <= mem_sign;
            op_off     <= address[1:0];
            op_reg     <= wb_reg;
            op_flushed <= 1'b0;
            wait_cnt   <= '0;
         end

         // A flush while waiting only remembers to drop the load writeback.
         if (state == ACCESS && flush) begin
            op_flushed <= 1'b1;
         end

         if (state == ACCESS && !ram_ack && !timeout) begin
            wait_cnt <= wait_cnt + CW'(1);
         end

         if (ack_done) begin
            ram_req <= 1'b0;
            if (!ram_we && !op_flushed && !flush) begin
               wb_valid   <= 1'b1;
               wb_data    <= load_data;
               wb_reg_out <= op_reg;
            end
         end

         if (timeout) begin
            ram_req   <= 1'b0;
            bus_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic        mem_sign = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic [31:0] ex_result = 32'd0;
   logic [4:0]  wb_reg = 5'd0;
   logic        ram_ack = 1'b0;
   logic [31:0] ram_rdata = 32'd0;
   logic        ram_req, ram_we, stall_req, wb_valid, addr_error, bus_error;
   logic [31:0] ram_addr, ram_wdata, wb_data;
   logic [3:0]  ram_sel;
   logic [4:0]  wb_reg_out;

   mem_access #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .mem_sign(mem_sign), .address(address), .write_data(write_data),
      .ex_result(ex_result), .wb_reg(wb_reg),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_sel(ram_sel), .ram_wdata(ram_wdata),
      .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .stall_req(stall_req), .wb_valid(wb_valid), .wb_reg_out(wb_reg_out),
      .wb_data(wb_data), .addr_error(addr_error), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Expected outputs for the current cycle, and values pending for the next one.
   logic        e_stall = 0, e_req = 0, e_we = 0, e_wbv = 0, e_aerr = 0, e_berr = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_wbdata = 0;
   logic [3:0]  e_sel = 0;
   logic [4:0]  e_wbreg = 0;
   logic        p_wbv = 0, p_aerr = 0, p_berr = 0, p_req_clr = 0;
   logic [31:0] p_wbdata = 0;
   logic [4:0]  p_wbreg = 0;

   // Observations gathered by the compare process, used for literal pins.
   int          stall_seen, req_seen, wb_seen, aerr_seen, berr_seen;
   logic [31:0] last_addr, last_wdata, last_wbdata;
   logic [3:0]  last_sel;
   logic        last_we;
   logic [4:0]  last_wbreg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-level arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [3:0] m_sel(input logic [1:0] s, input logic [31:0] a);
      logic [3:0] r = 4'd0;
      int off = int'(a % 4);
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + nbytes(s)) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] wd);
      logic [31:0] r = 32'd0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(s)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] s, input bit sg,
                                          input logic [31:0] a, input logic [31:0] rd);
      longint v = 0;
      int n = nbytes(s);
      int off = int'(a % 4);
      for (int i = 0; i < n; i++) v += longint'(rd[8*(off+i) +: 8]) << (8*i);
      if (sg && v >= (64'sd1 << (8*n-1))) v -= (64'sd1 << (8*n));
      return v[31:0];
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (check_en) begin
         chk("stall_req", 32'(stall_req), 32'(e_stall));
         chk("ram_req", 32'(ram_req), 32'(e_req));
         chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
         chk("addr_error", 32'(addr_error), 32'(e_aerr));
         chk("bus_error", 32'(bus_error), 32'(e_berr));
         if (e_req) begin
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_sel", 32'(ram_sel), 32'(e_sel));
            chk("ram_wdata", ram_wdata, e_wdata);
         end
         if (e_wbv) begin
            chk("wb_reg_out", 32'(wb_reg_out), 32'(e_wbreg));
            chk("wb_data", wb_data, e_wbdata);
         end
         if (stall_req) stall_seen++;
         if (ram_req) begin
            req_seen++;
            last_addr = ram_addr; last_sel = ram_sel; last_wdata = ram_wdata; last_we = ram_we;
         end
         if (wb_valid) begin
            wb_seen++;
            last_wbdata = wb_data; last_wbreg = wb_reg_out;
         end
         if (addr_error) aerr_seen++;
         if (bus_error) berr_seen++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic next();
      @(posedge clk); #1;
      ex_valid = 0; flush = 0; ram_ack = 0; mem_read = 0; mem_write = 0;
      e_stall = 0;
      e_wbv = p_wbv; e_wbreg = p_wbreg; e_wbdata = p_wbdata;
      e_aerr = p_aerr; e_berr = p_berr;
      if (p_req_clr) e_req = 0;
      p_wbv = 0; p_aerr = 0; p_berr = 0; p_req_clr = 0;
   endtask

   task automatic clr_seen();
      stall_seen = 0; req_seen = 0; wb_seen = 0; aerr_seen = 0; berr_seen = 0;
   endtask

   task automatic settle();
      next(); next();
      @(negedge clk); #1;
   endtask

   task automatic alu(input logic [31:0] res, input logic [4:0] r);
      next();
      ex_valid = 1; ex_result = res; wb_reg = r;
      p_wbv = 1; p_wbdata = res; p_wbreg = r;
   endtask

   // ack_after: no-ack ACCESS cycles before the ack (-1 = never ack).
   // flush_at: ACCESS cycle (1-based) carrying flush (-1 = none).
   task automatic mem_op(input bit wr, input logic [1:0] s, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                         input int ack_after, input int flush_at, input logic [31:0] rd);
      bit flushed = 0;
      next();
      ex_valid = 1; mem_read = !wr; mem_write = wr; mem_size = s; mem_sign = sg;
      address = a; write_data = wd; wb_reg = r;
      if ((a % nbytes(s)) != 0) begin
         p_aerr = 1;
         return;
      end
      e_stall = 1;
      for (int k = 1; k <= TO + 1; k++) begin
         next();
         e_req = 1; e_we = wr; e_addr = a & ~32'd3;
         e_sel = m_sel(s, a); e_wdata = m_wdata(s, wd);
         if (k == flush_at) begin
            flush = 1; flushed = 1;
         end
         if (k == ack_after + 1) begin
            ram_ack = 1; ram_rdata = rd;
            p_req_clr = 1;
            if (!wr && !flushed) begin
               p_wbv = 1; p_wbdata = m_load(s, sg, a, rd); p_wbreg = r;
            end
            break;
         end else if (k - 1 == TO) begin
            // TO wait cycles already counted with no ack: give up.
            p_req_clr = 1; p_berr = 1;
            break;
         end else begin
            e_stall = 1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_seen();
      // Reset with a would-be load on the inputs: stall must stay low.
      ex_valid = 1; mem_read = 1; mem_size = 2'b10; address = 32'h100;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_ram_req", 32'(ram_req), 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_sel", 32'(ram_sel), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_errs", {30'd0, addr_error, bus_error}, 32'd0);
      @(posedge clk); #1;
      rst = 0; ex_valid = 0; mem_read = 0;
      check_en = 1;

      // ALU pass-through
      clr_seen();
      alu(32'h1234_5678, 5'd3);
      settle();
      chk("alu_wb_count", wb_seen, 1);
      chk("alu_wb_data", last_wbdata, 32'h1234_5678);
      chk("alu_wb_reg", 32'(last_wbreg), 32'd3);
      chk("alu_no_req", req_seen, 0);

      // Back-to-back ALU ops: one pulse each
      clr_seen();
      alu(32'hDEAD_BEEF, 5'd5);
      alu(32'h0000_0001, 5'd7);
      settle();
      chk("alu2_wb_count", wb_seen, 2);

      // LB signed 0x1003, ack after 3 cycles
      clr_seen();
      mem_op(0, 2'b00, 1, 32'h1003, 32'h0, 5'd9, 3, -1, 32'h80FF_0000);
      settle();
      chk("lb_sel", 32'(last_sel), 32'b1000);
      chk("lb_addr", last_addr, 32'h1000);
      chk("lb_stall_cycles", stall_seen, 4);
      chk("lb_wb_data", last_wbdata, 32'hFFFF_FF80);
      chk("lb_wb_count", wb_seen, 1);

      // SH 0x2002, ack on first ACCESS cycle
      clr_seen();
      mem_op(1, 2'b01, 0, 32'h2002, 32'hAAAA_BEEF, 5'd4, 0, -1, 32'h0);
      settle();
      chk("sh_sel", 32'(last_sel), 32'b1100);
      chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
      chk("sh_we", 32'(last_we), 32'd1);
      chk("sh_no_wb", wb_seen, 0);

      // LW misaligned
      clr_seen();
      mem_op(0, 2'b10, 0, 32'h0006, 32'h0, 5'd6, 0, -1, 32'h0);
      settle();
      chk("lw_mis_aerr", aerr_seen, 1);
      chk("lw_mis_no_req", req_seen, 0);
      chk("lw_mis_no_wb", wb_seen, 0);

      // LHU 0x0006
      clr_seen();
      mem_op(0, 2'b01, 0, 32'h0006, 32'h0, 5'd8, 1, -1, 32'h8001_0000);
      settle();
      chk("lhu_wb_data", last_wbdata, 32'h0000_8001);

      // More lane patterns
      mem_op(1, 2'b00, 0, 32'h3001, 32'h1234_5678, 5'd0, 1, -1, 32'h0);
      mem_op(0, 2'b01, 1, 32'h3002, 32'h0, 5'd10, 0, -1, 32'h8765_4321);
      mem_op(0, 2'b00, 0, 32'h3000, 32'h0, 5'd11, 2, -1, 32'h0000_00F0);
      mem_op(1, 2'b10, 0, 32'h3004, 32'hCAFE_F00D, 5'd0, 2, -1, 32'h0);
      mem_op(0, 2'b10, 0, 32'h3008, 32'h0, 5'd12, 0, -1, 32'h0BAD_F00D);
      settle();

      // LW with no ack: timeout
      clr_seen();
      mem_op(0, 2'b10, 0, 32'h0010, 32'h0, 5'd13, -1, -1, 32'h0);
      settle();
      chk("to_berr", berr_seen, 1);
      chk("to_no_wb", wb_seen, 0);

      // Ack in the same cycle the counter reaches its limit: ack wins
      clr_seen();
      mem_op(0, 2'b10, 0, 32'h0014, 32'h0, 5'd14, TO, -1, 32'h5555_AAAA);
      settle();
      chk("tie_no_berr", berr_seen, 0);
      chk("tie_wb_data", last_wbdata, 32'h5555_AAAA);

      // Flush mid-LW, then ack
      clr_seen();
      mem_op(0, 2'b10, 0, 32'h0020, 32'h0, 5'd15, 2, 2, 32'h1111_2222);
      settle();
      chk("flush_acc_no_wb", wb_seen, 0);

      // Flush in IDLE, ack in IDLE, read+write and reserved-size no-ops
      clr_seen();
      next(); ex_valid = 1; mem_read = 1; mem_size = 2'b10; address = 32'h40; flush = 1;
      next(); ex_valid = 1; ex_result = 32'h77; flush = 1;
      next(); ram_ack = 1; ram_rdata = 32'hFFFF_FFFF;
      next(); ex_valid = 1; mem_read = 1; mem_write = 1; mem_size = 2'b10; address = 32'h44;
      next(); ex_valid = 1; mem_read = 1; mem_size = 2'b11; address = 32'h48;
      settle();
      chk("noop_no_req", req_seen, 0);
      chk("noop_no_wb", wb_seen, 0);

      // Reset in the middle of an access
      clr_seen();
      next(); ex_valid = 1; mem_read = 1; mem_size = 2'b10; address = 32'h50; wb_reg = 5'd2;
      e_stall = 1;
      next(); e_req = 1; e_we = 0; e_addr = 32'h50; e_sel = 4'b1111; e_wdata = 32'h0; e_stall = 1;
      write_data = 32'h0;
      next(); e_stall = 0; rst = 1;
      next(); rst = 0; e_req = 0;
      @(negedge clk); #1;
      chk("rst_mid_we", 32'(ram_we), 32'd0);
      chk("rst_mid_addr", ram_addr, 32'd0);
      chk("rst_mid_wdata", ram_wdata, 32'd0);
      chk("rst_mid_wb", {27'd0, wb_reg_out} | wb_data, 32'd0);
      next(); ram_ack = 1; ram_rdata = 32'h1234_0000;
      settle();
      chk("rst_mid_no_wb", wb_seen, 0);
      chk("rst_mid_no_err", aerr_seen + berr_seen, 0);

      check_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
